// File: rtl/score_pkg.sv
// ============================================================================
// Module   : score_pkg
// Purpose  : Shared BCD score types, seven-segment constants and decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package score_pkg;

    localparam int DIGITS = 4;

    typedef logic [3:0]              bcd_t;
    typedef bcd_t [DIGITS-1:0]       score_t;

    // Segment order {dp,g,f,e,d,c,b,a}, active-low, dp always off
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;

    function automatic logic [7:0] seg_decode(input bcd_t d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/score_bcd_counter.sv
// ============================================================================
// Module   : score_bcd_counter
// Purpose  : Saturating 4-digit BCD counter with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_bcd_counter
    import score_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   inc,
    input  logic   clr,
    output score_t score
);

    score_t              r_score;
    score_t              w_next;
    logic [DIGITS:0]     w_carry;
    logic                w_sat;

    // A digit advances only when every lower digit is wrapping from 9
    assign w_carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic w_is9;
        assign w_is9        = (r_score[i] == 4'd9);
        assign w_carry[i+1] = w_carry[i] && w_is9;
        assign w_next[i]    = !w_carry[i] ? r_score[i] :
                              (w_is9 ? 4'd0 : r_score[i] + 4'd1);
    end

    // Carry out of the top digit means the score is 9999
    assign w_sat = w_carry[DIGITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_score <= '0;
        end else if (clr) begin
            r_score <= '0;
        end else if (inc && !w_sat) begin
            r_score <= w_next;
        end
    end

    assign score = r_score;

endmodule

`default_nettype wire

// File: rtl/score_display.sv
// ============================================================================
// Module   : score_display
// Purpose  : Counts passed pipes in BCD and scans a 4-digit active-low
//            seven-segment display. Define HIGH_SCORE_EN for best-score keeping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_display
    import score_pkg::*;
#(
    parameter int SCAN_DIV_W = 17,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pass,
    input  logic        clr,
    input  logic        show_best,
    output logic [15:0] score,
    output logic [15:0] best,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_edge;
    logic                  r_inc;
    logic [SCAN_DIV_W-1:0] r_div;
    logic [7:0]            r_seg;
    logic [3:0]            r_an;

    score_t                w_score;
    score_t                w_best;
    score_t                w_disp;
    logic [1:0]            w_sel;
    logic [DIGITS-1:0]     w_lz;
    logic                  w_blank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_edge  <= 1'b0;
            r_inc   <= 1'b0;
        end else begin
            r_sync1 <= pass;
            r_sync2 <= r_sync1;
            r_edge  <= r_sync2;
            r_inc   <= r_sync2 && !r_edge;
        end
    end

    score_bcd_counter u_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (r_inc),
        .clr   (clr),
        .score (w_score)
    );

`ifdef HIGH_SCORE_EN
    score_t r_best;

    // Plain unsigned compare of packed BCD orders the same as decimal
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_best <= '0;
        end else if (clr && (w_score > r_best)) begin
            r_best <= w_score;
        end
    end

    assign w_best = r_best;
    assign w_disp = show_best ? r_best : w_score;
`else
    logic w_unused_show_best;

    assign w_unused_show_best = show_best;
    assign w_best             = '0;
    assign w_disp             = w_score;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_sel = r_div[SCAN_DIV_W-1:SCAN_DIV_W-2];

    // w_lz[k]: digit k and all higher digits are zero
    for (genvar k = 0; k < DIGITS; k++) begin : g_lz
        if (k == DIGITS - 1) begin : g_top
            assign w_lz[k] = (w_disp[k] == 4'd0);
        end else begin : g_low
            assign w_lz[k] = (w_disp[k] == 4'd0) && w_lz[k+1];
        end
    end

    assign w_blank = BLANK_LZ && (w_sel != 2'd0) && w_lz[w_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= SEG_BLANK;
            r_an  <= 4'hF;
        end else begin
            r_seg <= w_blank ? SEG_BLANK : seg_decode(w_disp[w_sel]);
            r_an  <= ~(4'b0001 << w_sel);
        end
    end

    assign score = w_score;
    assign best  = w_best;
    assign seg   = r_seg;
    assign an    = r_an;

endmodule

`default_nettype wire

// File: tb/tb_score_display.sv
// ============================================================================
// Module   : tb_score_display
// Purpose  : Directed self-checking bench for score_display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pass = 1'b0;
    logic        clr = 1'b0;
    logic        show_best = 1'b0;
    logic [15:0] score;
    logic [15:0] best;
    logic [7:0]  seg;
    logic [3:0]  an;

    int n_tests = 0;
    int n_fail  = 0;

    score_display #(
        .SCAN_DIV_W (6),
        .BLANK_LZ   (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pass      (pass),
        .clr       (clr),
        .show_best (show_best),
        .score     (score),
        .best      (best),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) pass = 1'b1;
            @(negedge clk) pass = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic do_clr();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    // Wait (bounded) for digit k to be selected, then check its segments
    task automatic show_digit(input string tag, input int k, input logic [7:0] exp);
        logic [3:0] a;
        int         n;
        a = 4'b0001 << k;
        a = ~a;
        n = 0;
        while (an !== a && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_an"}, an, a);
        check_val({tag, "_seg"}, seg, exp);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_score", score, 16'h0000);
        check_val("rst_best", best, 16'h0000);
        check_val("rst_seg", seg, 8'hFF);
        check_val("rst_an", an, 4'hF);

        // Scan: 16 clk per digit with SCAN_DIV_W = 6
        rst = 1'b0;
        @(posedge clk) #1;
        check_val("scan_e1", an, 4'hE);
        check_val("scan_seg_u", seg, 8'hC0);
        repeat (15) @(posedge clk);
        #1 check_val("scan_e16", an, 4'hE);
        @(posedge clk) #1;
        check_val("scan_d17", an, 4'hD);
        check_val("scan_seg_t", seg, 8'hFF);
        repeat (16) @(posedge clk);
        #1 check_val("scan_b33", an, 4'hB);
        check_val("scan_seg_h", seg, 8'hFF);
        repeat (16) @(posedge clk);
        #1 check_val("scan_749", an, 4'h7);
        check_val("scan_seg_k", seg, 8'hFF);
        repeat (16) @(posedge clk);
        #1 check_val("scan_e65", an, 4'hE);

        // Long pass level counts once, new value after edge N+3
        @(negedge clk) pass = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_val("lat_n2", score, 16'h0000);
        @(posedge clk) #1;
        check_val("lat_n3", score, 16'h0001);
        repeat (996) @(negedge clk);
        pass = 1'b0;
        repeat (5) @(negedge clk);
        check_val("hold_once", score, 16'h0001);
        do_clr();
        check_val("clr_1", score, 16'h0000);
        check_val("best_1", best, `ifdef HIGH_SCORE_EN 16'h0001 `else 16'h0000 `endif);

        pulse(9);
        check_val("cnt_9", score, 16'h0009);
        pulse(1);
        check_val("carry_10", score, 16'h0010);
        pulse(9);
        check_val("cnt_19", score, 16'h0019);
        repeat (2) @(negedge clk);
        show_digit("d19_u", 0, 8'h90);
        show_digit("d19_t", 1, 8'hF9);
        show_digit("d19_h", 2, 8'hFF);
        show_digit("d19_k", 3, 8'hFF);

        // clr held across incoming pulses keeps score at 0
        @(negedge clk) clr = 1'b1;
        pulse(3);
        clr = 1'b0;
        @(negedge clk);
        check_val("clr_hold", score, 16'h0000);

        pulse(37);
        do_clr();
        check_val("best_37", best, `ifdef HIGH_SCORE_EN 16'h0037 `else 16'h0000 `endif);
        pulse(12);
        check_val("cnt_12", score, 16'h0012);
        do_clr();
        check_val("best_keep", best, `ifdef HIGH_SCORE_EN 16'h0037 `else 16'h0000 `endif);

        show_best = 1'b1;
        repeat (2) @(negedge clk);
`ifdef HIGH_SCORE_EN
        show_digit("sb_u", 0, 8'hF8);
        show_digit("sb_t", 1, 8'hB0);
`else
        show_digit("sb_u", 0, 8'hC0);
        show_digit("sb_t", 1, 8'hFF);
`endif
        show_digit("sb_h", 2, 8'hFF);
        show_digit("sb_k", 3, 8'hFF);
        show_best = 1'b0;

        // clr coincident with inc at 0042: the increment is lost
        pulse(42);
        check_val("cnt_42", score, 16'h0042);
        @(negedge clk) pass = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        check_val("clr_inc", score, 16'h0000);
        pass = 1'b0;
        repeat (4) @(negedge clk);
        check_val("clr_inc_lost", score, 16'h0000);
        check_val("best_42", best, `ifdef HIGH_SCORE_EN 16'h0042 `else 16'h0000 `endif);

        pulse(9998);
        check_val("cnt_9998", score, 16'h9998);
        pulse(1);
        check_val("sat_1", score, 16'h9999);
        pulse(1);
        check_val("sat_2", score, 16'h9999);
        pulse(1);
        check_val("sat_3", score, 16'h9999);
        repeat (2) @(negedge clk);
        show_digit("d9999_k", 3, 8'h90);

        // Asynchronous reset mid-scan
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("arst_score", score, 16'h0000);
        check_val("arst_best", best, 16'h0000);
        check_val("arst_seg", seg, 8'hFF);
        check_val("arst_an", an, 4'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
